// File: rtl/ics_audio_out.sv
// Audio output stage: buffers irregular mixer samples and paces them out at OUT_HZ with volume/mute.
// Latency: out_l/out_r/out_strobe register two cycles after each pacer tick.
// Backpressure: none upstream; samples arriving at a full FIFO are dropped and flagged.
module ics_audio_fifo #(
  parameter int W  = 32,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdat,
  output logic [W-1:0]  rdat,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem [0:(1<<AW)-1];
  logic [AW-1:0] wp, rp;

  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Caller only pushes at full when popping the same cycle, so wp==rp reads the old head.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdat;
  end

  assign rdat = mem[rp];
endmodule

module ics_audio_out #(
  parameter int CLK_HZ     = 50000000,
  parameter int OUT_HZ     = 48000,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [15:0]           in_l,
  input  logic [15:0]           in_r,
  input  logic [7:0]            vol,
  input  logic                  mute,
  input  logic                  clr_flags,
  output logic [15:0]           out_l,
  output logic [15:0]           out_r,
  output logic                  out_strobe,
  output logic                  overflow,
  output logic                  underrun,
  output logic [DEPTH_LOG2:0]   level
);
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] LVL_HALF = (DEPTH_LOG2+1)'(1 << (DEPTH_LOG2-1));

  typedef struct packed {
    logic signed [15:0] l;
    logic signed [15:0] r;
  } sample_t;

  typedef enum logic {FILL, RUN} state_t;

  state_t      state;
  logic [31:0] acc;
  logic [32:0] acc_next;
  logic        tick;
  logic        pop, push, ovf_set, urn_set;
  sample_t     fifo_head;
  sample_t     s1_smp;
  logic [7:0]  s1_vol;
  logic        s1_vld, s1_hold;

  function automatic logic [15:0] scale(input logic signed [15:0] s, input logic [7:0] v);
    logic signed [24:0] p;
    p = 25'(s) * 25'($signed({1'b0, v}));
    p = p >>> 7;
    if (p > 25'sd32767)
      return 16'h7FFF;
    else if (p < -25'sd32768)
      return 16'h8000;
    else
      return p[15:0];
  endfunction

  // Fractional pacer: tick is registered, so it is high the cycle after the wrap.
  assign acc_next = {1'b0, acc} + 33'(OUT_HZ);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (acc_next >= 33'(CLK_HZ)) begin
      acc  <= acc_next[31:0] - 32'(CLK_HZ);
      tick <= 1'b1;
    end else begin
      acc  <= acc_next[31:0];
      tick <= 1'b0;
    end
  end

  assign pop     = tick && (state == RUN) && (level != '0);
  assign urn_set = tick && (state == RUN) && (level == '0);
  assign push    = in_valid && ((level < LVL_FULL) || pop);
  assign ovf_set = in_valid && !push;

  ics_audio_fifo #(.W(32), .AW(DEPTH_LOG2)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdat  ({in_l, in_r}),
    .rdat  (fifo_head),
    .count (level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FILL;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      case (state)
        FILL:    if (level >= LVL_HALF) state <= RUN;
        RUN:     if (urn_set) state <= FILL;
        default: state <= FILL;
      endcase
      if (ovf_set)        overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
      if (urn_set)        underrun <= 1'b1;
      else if (clr_flags) underrun <= 1'b0;
    end
  end

  // Select stage: FILL ticks and muted pops feed zero; an underrun tick marks a hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld  <= 1'b0;
      s1_hold <= 1'b0;
      s1_smp  <= '0;
      s1_vol  <= '0;
    end else begin
      s1_vld  <= tick;
      s1_hold <= urn_set;
      if (tick) begin
        s1_vol <= vol;
        s1_smp <= (pop && !mute) ? fifo_head : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_strobe <= 1'b0;
      out_l      <= '0;
      out_r      <= '0;
    end else begin
      out_strobe <= s1_vld;
      if (s1_vld && !s1_hold) begin
        out_l <= scale(s1_smp.l, s1_vol);
        out_r <= scale(s1_smp.r, s1_vol);
      end
    end
  end
endmodule
